btn_conditioner: RTL

- Conditions one raw push-button input (up, down, mode or adjust) into clean single-cycle events for the clock's state machine and digit-adjust logic.
- This is the input end of the user interface; the display scan path is the output end.
- Stages: 2-FF synchroniser, press/release debouncer, hold detector with auto-repeat.
- One instance per button, all in the 50 MHz clock domain.

---
 rtl/btn_conditioner.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns one raw push-button pin into clean, registered
// single-cycle events (press, release, auto-repeat) plus a debounced level
// and a long-press flag. Stages: polarity fix, 2-FF synchroniser, debounce
// FSM with hold/repeat timing.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic enable_repeat,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press
);

  // Counter width covers the largest of the three timing parameters.
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DB_PRESS   = 3'd1;
  localparam logic [2:0] S_HELD       = 3'd2;
  localparam logic [2:0] S_REPEAT     = 3'd3;
  localparam logic [2:0] S_DB_RELEASE = 3'd4;

  logic          norm_in;
  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          from_rep_q, from_rep_d;   // DB_RELEASE was entered from REPEAT
  logic          level_q, level_d;
  logic          lp_q, lp_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rep_q, rep_d;

  // Pressed is always 1 after this point, whatever the pin polarity.
  assign norm_in = ACTIVE_HIGH ? btn_in : ~btn_in;

  // Two-flop synchroniser; resets to the not-pressed level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= norm_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: debounce both edges, then time hold and repeat.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    hcnt_d     = hcnt_q;
    from_rep_d = from_rep_q;
    level_d    = level_q;
    lp_d       = lp_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    rep_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sync2_q) begin
          state_d = S_DB_PRESS;
          dcnt_d  = '0;
        end
      end
      S_DB_PRESS: begin
        if (!sync2_q) begin
          state_d = S_IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      S_HELD: begin
        if (!sync2_q) begin
          state_d    = S_DB_RELEASE;
          dcnt_d     = '0;
          from_rep_d = 1'b0;
        end else if (hcnt_q == RD_LAST) begin
          // Counter stays saturated here until repeats are allowed.
          if (enable_repeat) begin
            state_d = S_REPEAT;
            rep_d   = 1'b1;
            lp_d    = 1'b1;
            hcnt_d  = '0;
          end
        end else begin
          hcnt_d = hcnt_q + ONE;
        end
      end
      S_REPEAT: begin
        if (!sync2_q) begin
          state_d    = S_DB_RELEASE;
          dcnt_d     = '0;
          from_rep_d = 1'b1;
        end else if (hcnt_q == RP_LAST) begin
          // Cadence keeps running even when the pulse is suppressed.
          hcnt_d = '0;
          rep_d  = enable_repeat;
        end else begin
          hcnt_d = hcnt_q + ONE;
        end
      end
      S_DB_RELEASE: begin
        // hcnt is left untouched so a release glitch does not shift timing
        // beyond the cycles spent here.
        if (sync2_q) begin
          state_d = from_rep_q ? S_REPEAT : S_HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d = S_IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
          lp_d    = 1'b0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      from_rep_q <= 1'b0;
      level_q    <= 1'b0;
      lp_q       <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      from_rep_q <= from_rep_d;
      level_q    <= level_d;
      lp_q       <= lp_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      rep_q      <= rep_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rep_q;
  assign long_press    = lp_q;

endmodule
